// File: rtl/comefa_swizzle_pkg.sv
// Shared constants and sequencer state encoding for the swizzle load path.
// Contents:
//   COUNT_TO_SWITCH_BUFFERS - beats per swizzle buffer switch (one group)
//   MEM_CTRL_DWIDTH         - memory-controller / RAM data beat width
//   seq_state_t             - load sequencer states IDLE/REQ/STREAM/DRAIN
package comefa_swizzle_pkg;

   localparam int unsigned COUNT_TO_SWITCH_BUFFERS = 40;
   localparam int unsigned MEM_CTRL_DWIDTH         = 40;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/swz_desc_fifo.sv
// Synchronous descriptor FIFO with registered full/empty flags.
// Ports:
//   clk, resetn  - clock, synchronous active-low reset
//   push, wdata  - write request (ignored while full) and payload
//   pop          - read request (ignored while empty)
//   rdata        - head entry, valid while !empty
//   full, empty  - registered occupancy flags
module swz_desc_fifo #(
   parameter int unsigned WIDTH = 54,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Occupancy after this cycle's push/pop; flags are registered from it.
   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + CW'(1);
      end else if (do_pop && !do_push) begin
         count_nxt = count - CW'(1);
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/swizzle_load_sequencer.sv
// Sequences DRAM-to-CRAM load jobs: queues descriptors, issues one DRAM read
// burst per job, forwards beats to the swizzle one cycle later and waits for
// the swizzle to flush before starting the next job.
// Ports:
//   clk, resetn                  - clock, synchronous active-low reset
//   desc_*                       - descriptor push (valid/ready + fields)
//   rd_req_*                     - DRAM read request (addr, len in beats)
//   rd_data_valid/ready, rd_data - DRAM read data
//   sw_data_valid/last, sw_data  - beat stream into the swizzle
//   sw_start_addr, sw_dma_mode   - per-job swizzle settings, held between pops
//   sw_ready                     - swizzle flushed/ready
//   busy, done, err              - status: active, job-complete pulse, sticky error
module swizzle_load_sequencer
   import comefa_swizzle_pkg::*;
#(
   parameter int unsigned DWIDTH      = MEM_CTRL_DWIDTH,
   parameter int unsigned GROUP       = COUNT_TO_SWITCH_BUFFERS,
   parameter int unsigned DRAM_AWIDTH = 32,
   parameter int unsigned CRAM_AWIDTH = 13,
   parameter int unsigned GRP_W       = 8,
   parameter int unsigned LEN_W       = 16,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   desc_valid,
   output logic                   desc_ready,
   input  logic [DRAM_AWIDTH-1:0] desc_dram_addr,
   input  logic [GRP_W-1:0]       desc_groups,
   input  logic [CRAM_AWIDTH-1:0] desc_cram_addr,
   input  logic                   desc_dma_mode,
   output logic                   rd_req_valid,
   input  logic                   rd_req_ready,
   output logic [DRAM_AWIDTH-1:0] rd_req_addr,
   output logic [LEN_W-1:0]       rd_req_len,
   input  logic                   rd_data_valid,
   output logic                   rd_data_ready,
   input  logic [DWIDTH-1:0]      rd_data,
   output logic                   sw_data_valid,
   output logic                   sw_data_last,
   output logic [DWIDTH-1:0]      sw_data,
   output logic [CRAM_AWIDTH-1:0] sw_start_addr,
   output logic                   sw_dma_mode,
   input  logic                   sw_ready,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int unsigned DESC_W = DRAM_AWIDTH + GRP_W + CRAM_AWIDTH + 1;

   seq_state_t             state;
   seq_state_t             next_state;
   logic [DESC_W-1:0]      fifo_wdata;
   logic [DESC_W-1:0]      fifo_rdata;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;
   logic                   beat_acc;
   logic                   drain_guard;
   logic [LEN_W-1:0]       beats_left;
   logic [LEN_W-1:0]       head_len;
   logic [DRAM_AWIDTH-1:0] head_addr;
   logic [GRP_W-1:0]       head_groups;
   logic [CRAM_AWIDTH-1:0] head_cram;
   logic                   head_dma;

   assign fifo_wdata = {desc_dram_addr, desc_groups, desc_cram_addr, desc_dma_mode};
   assign {head_addr, head_groups, head_cram, head_dma} = fifo_rdata;

   assign desc_ready = !fifo_full;
   assign pop        = (state == IDLE) && !fifo_empty && sw_ready;
   assign beat_acc   = rd_data_valid && rd_data_ready;

   swz_desc_fifo #(
      .WIDTH (DESC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_desc_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (desc_valid),
      .wdata  (fifo_wdata),
      .pop    (pop),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // Burst length in beats; shift-add form of groups*40 avoids a multiplier.
   always_comb begin
      head_len = '0;
      if (GROUP == 40) begin
         head_len = (LEN_W'(head_groups) << 5) + (LEN_W'(head_groups) << 3);
      end else begin
         head_len = LEN_W'(head_groups) * LEN_W'(GROUP);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (pop && (head_groups != '0)) next_state = REQ;
         REQ:     if (rd_req_ready) next_state = STREAM;
         STREAM:  if (beat_acc && (beats_left == LEN_W'(1))) next_state = DRAIN;
         DRAIN:   if (!drain_guard && sw_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      rd_req_valid  = 1'b0;
      rd_data_ready = 1'b0;
      busy          = !fifo_empty;
      case (state)
         REQ:     rd_req_valid  = 1'b1;
         STREAM:  rd_data_ready = 1'b1;
         default: ;
      endcase
      if (state != IDLE) busy = 1'b1;
   end

   // Job registers, beat forwarding and status flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_req_addr   <= '0;
         rd_req_len    <= '0;
         beats_left    <= '0;
         sw_start_addr <= '0;
         sw_dma_mode   <= 1'b0;
         sw_data       <= '0;
         sw_data_valid <= 1'b0;
         sw_data_last  <= 1'b0;
         drain_guard   <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         done          <= 1'b0;
         sw_data_valid <= beat_acc;
         sw_data_last  <= beat_acc && (beats_left == LEN_W'(1));
         // First DRAIN cycle ignores sw_ready so the swizzle can take the last beat.
         drain_guard   <= (state == STREAM) && (next_state == DRAIN);
         if (beat_acc) begin
            sw_data    <= rd_data;
            beats_left <= beats_left - LEN_W'(1);
         end
         if (pop) begin
            rd_req_addr   <= head_addr;
            rd_req_len    <= head_len;
            beats_left    <= head_len;
            sw_start_addr <= head_cram;
            sw_dma_mode   <= head_dma;
            if (head_groups == '0) begin
               err  <= 1'b1;
               done <= 1'b1;
            end
         end
         if ((state == DRAIN) && (next_state == IDLE)) begin
            done <= 1'b1;
         end
      end
   end

endmodule
